// File: rtl/cycle_sequencer.sv
// Bus-cycle sequencer for on-board targets: picks the claiming target, counts its
// wait states, then issues a single STERM (or BERR on DS20 timeout) with registered outputs.
module cycle_sequencer #(
  parameter int RAM_WAIT   = 1,
  parameter int ZII_WAIT   = 2,
  parameter int SPI_WAIT   = 3,
  parameter int GAYLE_WAIT = 2,
  parameter int TIMEOUT    = 63
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       AS20,
  input  logic       DS20,
  input  logic       RW20,
  input  logic       RAM_DEC,
  input  logic       ZII_DEC,
  input  logic       SPI_DEC,
  input  logic       GAYLE_DEC,
  output logic       STERM,
  output logic       INTCYCLE,
  output logic       BERR,
  output logic       DOE,
  output logic [1:0] SEL,
  output logic       RAMSTB
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_TERM    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;
  localparam logic [2:0] S_PASS    = 3'd5;

  logic [2:0] state_reg, state_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic [7:0] tout_cnt_reg, tout_cnt_next;
  logic       sterm_reg, sterm_next;
  logic       intcycle_reg, intcycle_next;
  logic       berr_reg, berr_next;
  logic       doe_reg, doe_next;
  logic [1:0] sel_reg, sel_next;
  logic       ramstb_reg, ramstb_next;

  logic       dec_any;
  logic [1:0] win_sel;
  logic [3:0] win_wait;
  logic [3:0] wait_dec;
  logic [7:0] tout_inc;

  // Fixed claim priority: RAM > ZII > SPI > GAYLE
  always_comb begin
    win_sel  = 2'b11;
    win_wait = 4'(GAYLE_WAIT);
    if (!RAM_DEC) begin
      win_sel  = 2'b00;
      win_wait = 4'(RAM_WAIT);
    end else if (!ZII_DEC) begin
      win_sel  = 2'b01;
      win_wait = 4'(ZII_WAIT);
    end else if (!SPI_DEC) begin
      win_sel  = 2'b10;
      win_wait = 4'(SPI_WAIT);
    end
  end

  assign dec_any  = ~(RAM_DEC & ZII_DEC & SPI_DEC & GAYLE_DEC);
  assign wait_dec = (wait_cnt_reg == 4'd0) ? 4'd0 : wait_cnt_reg - 4'd1;
  assign tout_inc = tout_cnt_reg + 8'd1;

  // Output *_next values describe the state being entered, so outputs stay registered.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    tout_cnt_next = tout_cnt_reg;
    sterm_next    = 1'b1;
    intcycle_next = 1'b1;
    berr_next     = 1'b1;
    doe_next      = 1'b0;
    sel_next      = sel_reg;
    ramstb_next   = 1'b1;
    case (state_reg)
      S_IDLE: begin
        sel_next = 2'b00;
        if (!AS20) state_next = S_DECODE;
      end
      S_DECODE: begin
        tout_cnt_next = 8'd0;
        if (AS20) begin
          state_next = S_IDLE;
          sel_next   = 2'b00;
        end else if (dec_any) begin
          state_next    = S_WAIT;
          sel_next      = win_sel;
          wait_cnt_next = win_wait;
          intcycle_next = 1'b0;
          ramstb_next   = (win_sel != 2'b00);
          doe_next      = RW20 && (win_sel != 2'b00);
        end else begin
          state_next = S_PASS;
          sel_next   = 2'b00;
        end
      end
      S_WAIT: begin
        if (AS20) begin
          state_next = S_IDLE;
          sel_next   = 2'b00;
        end else begin
          intcycle_next = 1'b0;
          ramstb_next   = (sel_reg != 2'b00);
          doe_next      = RW20 && (sel_reg != 2'b00);
          if (tout_cnt_reg == 8'(TIMEOUT)) begin
            // BERR was shown last clock; the counter holds at TIMEOUT
            state_next  = S_RECOVER;
            ramstb_next = 1'b1;
            doe_next    = 1'b0;
          end else if (!DS20) begin
            wait_cnt_next = wait_dec;
            if (wait_dec == 4'd0) begin
              state_next = S_TERM;
              sterm_next = 1'b0;
            end
          end else begin
            tout_cnt_next = tout_inc;
            if (tout_inc == 8'(TIMEOUT)) berr_next = 1'b0;
          end
        end
      end
      S_TERM: begin
        state_next    = S_RECOVER;
        intcycle_next = 1'b0;
      end
      S_RECOVER: begin
        intcycle_next = 1'b0;
        if (AS20) begin
          state_next    = S_IDLE;
          intcycle_next = 1'b1;
          sel_next      = 2'b00;
        end
      end
      S_PASS: begin
        sel_next = 2'b00;
        if (AS20) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        sel_next   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      tout_cnt_reg <= 8'd0;
      sterm_reg    <= 1'b1;
      intcycle_reg <= 1'b1;
      berr_reg     <= 1'b1;
      doe_reg      <= 1'b0;
      sel_reg      <= 2'b00;
      ramstb_reg   <= 1'b1;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      tout_cnt_reg <= tout_cnt_next;
      sterm_reg    <= sterm_next;
      intcycle_reg <= intcycle_next;
      berr_reg     <= berr_next;
      doe_reg      <= doe_next;
      sel_reg      <= sel_next;
      ramstb_reg   <= ramstb_next;
    end
  end

  assign STERM    = sterm_reg;
  assign INTCYCLE = intcycle_reg;
  assign BERR     = berr_reg;
  assign DOE      = doe_reg;
  assign SEL      = sel_reg;
  assign RAMSTB   = ramstb_reg;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: directed transaction table, reset sequences,
// and randomized transactions checked against an edge-timing model.
module tb_cycle_sequencer;

  localparam int W_RAM = 1, W_ZII = 2, W_SPI = 3, W_GAYLE = 2, T_OUT = 63;
  localparam int NEVER = 1000;

  logic       CLKCPU = 1'b0;
  logic       RESET, AS20, DS20, RW20;
  logic       RAM_DEC, ZII_DEC, SPI_DEC, GAYLE_DEC;
  logic       STERM, INTCYCLE, BERR, DOE, RAMSTB;
  logic [1:0] SEL;

  int n_checks = 0;
  int n_fail   = 0;

  cycle_sequencer dut (
    .CLKCPU(CLKCPU), .RESET(RESET), .AS20(AS20), .DS20(DS20), .RW20(RW20),
    .RAM_DEC(RAM_DEC), .ZII_DEC(ZII_DEC), .SPI_DEC(SPI_DEC), .GAYLE_DEC(GAYLE_DEC),
    .STERM(STERM), .INTCYCLE(INTCYCLE), .BERR(BERR), .DOE(DOE), .SEL(SEL), .RAMSTB(RAMSTB)
  );

  always #5 CLKCPU = ~CLKCPU;

  // One transaction: dec = {GAYLE,SPI,ZII,RAM} active-low, DS20 low from edge d,
  // AS20 sampled high from edge r. Expected edges (0 = never) and select.
  typedef struct {
    logic [3:0] dec;
    logic       rw;
    int         d;
    int         r;
    int         sterm;
    int         berr;
    int         int_last;
    int         doe_last;
    int         ramstb_last;
    logic [1:0] sel;
  } vec_t;

  logic       obs_sterm [0:127];
  logic       obs_berr  [0:127];
  logic       obs_int   [0:127];
  logic       obs_doe   [0:127];
  logic       obs_rstb  [0:127];
  logic [1:0] obs_sel   [0:127];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {STERM, INTCYCLE, BERR, DOE, SEL, RAMSTB};
  endfunction

  // Timing model from the edge-counting rules: WAIT starts at edge 2, DS20 samples count from edge 3.
  function automatic vec_t model(input logic [3:0] dec, input logic rw, input int d, input int r);
    vec_t v;
    int   w, n, ds0, t, b, e;
    int   waits [4] = '{W_RAM, W_ZII, W_SPI, W_GAYLE};
    bit   active;
    v.dec = dec; v.rw = rw; v.d = d; v.r = r;
    active = (dec != 4'hF) && (r > 2);
    w = !dec[0] ? 0 : !dec[1] ? 1 : !dec[2] ? 2 : 3;
    n = (waits[w] < 1) ? 1 : waits[w];
    ds0 = (d < 3) ? 3 : d;
    if (ds0 - 3 >= T_OUT) begin
      b = 2 + T_OUT;
      t = NEVER;
    end else begin
      t = ds0 + n - 1;
      b = NEVER;
    end
    e = t;
    if (b < e) e = b;
    if (r - 1 < e) e = r - 1;
    v.sterm       = (active && t < r) ? t : 0;
    v.berr        = (active && b < r) ? b : 0;
    v.int_last    = !active ? 0 : (v.sterm != 0 && t + 1 > r - 1) ? t + 1 : r - 1;
    v.doe_last    = (active && w != 0 && rw) ? e : 0;
    v.ramstb_last = (active && w == 0) ? e : 0;
    v.sel         = active ? 2'(w) : 2'b00;
    return v;
  endfunction

  task automatic run_txn(input logic [3:0] dec, input logic rw, input int d, input int r);
    for (int k = 1; k <= r + 1; k++) begin
      AS20 = (k < r) ? 1'b0 : 1'b1;
      DS20 = (k >= d && k < r) ? 1'b0 : 1'b1;
      RW20 = rw;
      {GAYLE_DEC, SPI_DEC, ZII_DEC, RAM_DEC} = (k == 2) ? dec : 4'($urandom);
      @(posedge CLKCPU); #1;
      obs_sterm[k] = STERM;
      obs_berr[k]  = BERR;
      obs_int[k]   = INTCYCLE;
      obs_doe[k]   = DOE;
      obs_rstb[k]  = RAMSTB;
      obs_sel[k]   = SEL;
      @(negedge CLKCPU);
    end
  endtask

  task automatic check_txn(input vec_t v, input string tag);
    int st_first = 0, st_cnt = 0, be_first = 0, be_cnt = 0;
    int in_last = 0, in_cnt = 0, de_last = 0, de_cnt = 0, rs_last = 0, rs_cnt = 0;
    for (int k = 1; k <= v.r + 1; k++) begin
      if (!obs_sterm[k]) begin if (st_first == 0) st_first = k; st_cnt++; end
      if (!obs_berr[k])  begin if (be_first == 0) be_first = k; be_cnt++; end
      if (!obs_int[k])   begin in_last = k; in_cnt++; end
      if (obs_doe[k])    begin de_last = k; de_cnt++; end
      if (!obs_rstb[k])  begin rs_last = k; rs_cnt++; end
    end
    chk({tag, " sterm_edge"}, st_first, v.sterm);
    chk({tag, " sterm_count"}, st_cnt, int'(v.sterm != 0));
    chk({tag, " berr_edge"}, be_first, v.berr);
    chk({tag, " berr_count"}, be_cnt, int'(v.berr != 0));
    chk({tag, " intcycle_last"}, in_last, v.int_last);
    chk({tag, " intcycle_count"}, in_cnt, (v.int_last != 0) ? v.int_last - 1 : 0);
    chk({tag, " doe_last"}, de_last, v.doe_last);
    chk({tag, " doe_count"}, de_cnt, (v.doe_last != 0) ? v.doe_last - 1 : 0);
    chk({tag, " ramstb_last"}, rs_last, v.ramstb_last);
    chk({tag, " ramstb_count"}, rs_cnt, (v.ramstb_last != 0) ? v.ramstb_last - 1 : 0);
    chk({tag, " sel_edge2"}, int'(obs_sel[2]), int'(v.sel));
    chk({tag, " idle_after"}, int'({obs_sterm[v.r + 1], obs_int[v.r + 1], obs_berr[v.r + 1],
                                    obs_doe[v.r + 1], obs_sel[v.r + 1], obs_rstb[v.r + 1]}),
        int'(7'b1110001));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    vec_t v;
    logic [3:0] dec;
    logic rw;
    int d, r;

    // dec, rw, d, r, sterm, berr, int_last, doe_last, ramstb_last, sel
    tbl[0] = '{4'b1011, 1'b1, 1,     7,  5,  0,  6,  5,  0, 2'b10}; // SPI read
    tbl[1] = '{4'b0110, 1'b0, 1,     5,  3,  0,  4,  0,  3, 2'b00}; // RAM beats Gayle, write
    tbl[2] = '{4'b1111, 1'b1, 1,     5,  0,  0,  0,  0,  0, 2'b00}; // unclaimed: PASS
    tbl[3] = '{4'b1101, 1'b1, NEVER, 70, 0,  65, 69, 65, 0, 2'b01}; // ZII timeout
    tbl[4] = '{4'b0111, 1'b1, 1,     4,  0,  0,  3,  3,  0, 2'b11}; // Gayle abort at count 1
    tbl[5] = '{4'b1101, 1'b1, 5,     9,  6,  0,  8,  6,  0, 2'b01}; // late DS20
    tbl[6] = '{4'b1110, 1'b1, 1,     2,  0,  0,  0,  0,  0, 2'b00}; // abort in DECODE
    tbl[7] = '{4'b1110, 1'b1, 1,     15, 3,  0,  14, 0,  3, 2'b00}; // long AS20: one STERM
    tbl[8] = '{4'b1011, 1'b0, 2,     6,  5,  0,  6,  0,  0, 2'b10}; // AS20 rises during TERM

    // Reset held with a claimed cycle pending
    RESET = 1'b0; AS20 = 1'b0; DS20 = 1'b0; RW20 = 1'b1;
    RAM_DEC = 1'b0; ZII_DEC = 1'b1; SPI_DEC = 1'b1; GAYLE_DEC = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLKCPU); #1;
      chk($sformatf("reset_outputs_%0d", i), int'(outs()), int'(7'b1110001));
    end
    @(negedge CLKCPU); RESET = 1'b1; DS20 = 1'b1;
    @(posedge CLKCPU); #1;
    chk("post_reset_decode_intcycle", int'(INTCYCLE), 1);
    @(posedge CLKCPU); #1;
    chk("post_reset_wait_intcycle", int'(INTCYCLE), 0);
    chk("post_reset_wait_ramstb", int'(RAMSTB), 0);
    // Reset in the middle of WAIT: no STERM or BERR pulse
    @(negedge CLKCPU); RESET = 1'b0; DS20 = 1'b0;
    @(posedge CLKCPU); #1;
    chk("midcycle_reset_outputs", int'(outs()), int'(7'b1110001));
    @(negedge CLKCPU); AS20 = 1'b1;
    @(posedge CLKCPU); #1;
    chk("reset_hold_outputs", int'(outs()), int'(7'b1110001));
    @(negedge CLKCPU); RESET = 1'b1; DS20 = 1'b1;
    @(posedge CLKCPU); #1;
    chk("released_idle_outputs", int'(outs()), int'(7'b1110001));
    @(negedge CLKCPU);

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].dec, tbl[i].rw, tbl[i].d, tbl[i].r);
      check_txn(tbl[i], $sformatf("vec%0d", i));
      $display("vec%0d dec=%b rw=%0d d=%0d r=%0d", i, tbl[i].dec, tbl[i].rw, tbl[i].d, tbl[i].r);
    end

    for (int i = 0; i < 40; i++) begin
      dec = 4'($urandom);
      if ($urandom_range(0, 5) == 0) dec = 4'hF;
      rw = 1'($urandom);
      d  = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 8));
      r  = int'($urandom_range(2, (d == NEVER) ? 70 : 16));
      v  = model(dec, rw, d, r);
      run_txn(dec, rw, d, r);
      check_txn(v, $sformatf("rnd%0d", i));
      $display("rnd%0d dec=%b rw=%0d d=%0d r=%0d sterm=%0d berr=%0d", i, dec, rw, d, r,
               v.sterm, v.berr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
